nios2_system_v0_edge_pio: RTL

- Parametrised input PIO, Avalon-MM slave, for switch/button inputs on the Nios II system bus.
- Successor to the fixed 8-bit input port. Adds:
  - generic width;
  - 2-flop input synchroniser;
  - per-bit edge capture with selectable edge type;
  - interrupt mask and level IRQ output to the CPU.

---
 rtl/nios2_system_v0_pio_pkg.sv | 16 +
 rtl/nios2_system_v0_pio_debounce.sv | 31 +++
 rtl/nios2_system_v0_edge_pio.sv | 98 +++++++++
 3 files changed

// File: rtl/nios2_system_v0_pio_pkg.sv
// Shared constants for the Nios II edge-capture input PIO: register word
// addresses and the edge-type encodings used by the EDGE_TYPE parameter.
package nios2_system_v0_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage

// File: rtl/nios2_system_v0_pio_debounce.sv
// One-bit debouncer: the stable output follows the raw input only after the
// raw input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module nios2_system_v0_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios2_system_v0_edge_pio.sv
// Avalon-MM input PIO with 2-flop synchroniser, per-bit edge capture and a
// masked level IRQ. Define NIOS2_SYSTEM_V0_EDGE_PIO_DEBOUNCE_EN to debounce inputs.
module nios2_system_v0_edge_pio
  import nios2_system_v0_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    EDGE_TYPE       = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_MASK      = '0,
  parameter int                    DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] sync1, sync2, din, prev;
  logic [DATA_WIDTH-1:0] edgecap, irqmask, edges, clr;
  logic [31:0]           din_ext, mask_ext, ec_ext, rd_next;
  logic                  wr;
  logic                  unused_writedata;

  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef NIOS2_SYSTEM_V0_EDGE_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_db
    nios2_system_v0_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (sync2[i]),
      .stable (din[i])
    );
  end
`else
  assign din = sync2;
`endif

  always_comb begin
    case (EDGE_TYPE)
      int'(EDGE_FALL): edges = ~din & prev;
      int'(EDGE_ANY):  edges = din ^ prev;
      default:         edges = din & ~prev;
    endcase
  end

  assign wr  = chipselect & ~write_n;
  assign clr = (wr && address == ADDR_EDGECAP) ? writedata[DATA_WIDTH-1:0] : '0;

  always_comb begin
    din_ext  = '0;
    mask_ext = '0;
    ec_ext   = '0;
    din_ext[DATA_WIDTH-1:0]  = din;
    mask_ext[DATA_WIDTH-1:0] = irqmask;
    ec_ext[DATA_WIDTH-1:0]   = edgecap;
    case (address)
      ADDR_DATA:    rd_next = din_ext;
      ADDR_IRQMASK: rd_next = mask_ext;
      ADDR_EDGECAP: rd_next = ec_ext;
      default:      rd_next = '0;
    endcase
  end

  // Reads and irq see pre-write state; a new edge outranks a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      edgecap  <= '0;
      irqmask  <= RESET_MASK;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= din;
      edgecap  <= (edgecap & ~clr) | edges;
      if (wr && address == ADDR_IRQMASK) irqmask <= writedata[DATA_WIDTH-1:0];
      readdata <= rd_next;
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule
